// File: rtl/z80_busrq_dma_pkg.sv
// Shared types and constants for the z80_busrq_dma bus-request DMA scheduler.
package z80_dma_pkg;

  localparam int ADDR_W = 16;
  localparam int LEN_W  = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    RD        = 3'd2,
    WR        = 3'd3,
    REL_BURST = 3'd4,
    REL_LAST  = 3'd5,
    HOLD      = 3'd6,
    DONE      = 3'd7
  } dma_state_e;

  // Strobe bundle ordering is {mreq_n, rd_n, wr_n}.
  localparam logic [2:0] BUS_IDLE = 3'b111;
  localparam logic [2:0] BUS_RD   = 3'b001;
  localparam logic [2:0] BUS_WR   = 3'b010;

  function automatic logic [2:0] strobes_for(input dma_state_e st);
    logic [2:0] stb;
    case (st)
      RD:      stb = BUS_RD;
      WR:      stb = BUS_WR;
      default: stb = BUS_IDLE;
    endcase
    return stb;
  endfunction

endpackage

// File: rtl/z80_busrq_dma_burst_timer.sv
// Tenure byte counter and bus-release holdoff counter for z80_busrq_dma.
module dma_burst_timer
  import z80_dma_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int HOLDOFF   = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic byte_done,
  input  logic burst_clr,
  input  logic hold_en,
  output logic burst_limit,
  output logic holdoff_expired
);

  logic [LEN_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [LEN_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [LEN_W-1:0] hold_cnt_inc_s;

  // burst_limit flags that the byte now being written closes the current tenure.
  always_comb begin
    hold_cnt_inc_s  = hold_cnt_q + 16'd1;
    holdoff_expired = hold_en && (hold_cnt_inc_s >= LEN_W'(HOLDOFF));
    if (MAX_BURST != 0) begin
      burst_limit = ((burst_cnt_q + 16'd1) == LEN_W'(MAX_BURST));
    end else begin
      burst_limit = 1'b0;
    end

    if (burst_clr) begin
      burst_cnt_d = 16'd0;
    end else if (byte_done) begin
      burst_cnt_d = burst_cnt_q + 16'd1;
    end else begin
      burst_cnt_d = burst_cnt_q;
    end

    if (hold_en && !holdoff_expired) begin
      hold_cnt_d = hold_cnt_inc_s;
    end else begin
      hold_cnt_d = 16'd0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt_q <= 16'd0;
      hold_cnt_q  <= 16'd0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/z80_busrq_dma.sv
// Bus-request DMA block copier for the tv80s bus; takes the bus via busrq_n/busak_n.
// Optional fill mode is enabled by defining DMA_FILL_EN.
module z80_busrq_dma
  import z80_dma_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int HOLDOFF   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic              fill,
  output logic              busy,
  output logic              done,
  output logic              busrq_n,
  input  logic              busak_n,
  output logic              dma_bus_en,
  output logic [ADDR_W-1:0] dma_a,
  output logic [DATA_W-1:0] dma_do,
  input  logic [DATA_W-1:0] dma_di,
  output logic              dma_mreq_n,
  output logic              dma_rd_n,
  output logic              dma_wr_n
);

`ifdef DMA_FILL_EN
  localparam logic FILL_EN = 1'b1;
`else
  localparam logic FILL_EN = 1'b0;
`endif

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, dma_a_q, dma_a_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] dma_do_q, dma_do_d;
  logic              fill_q, fill_d, fill_have_q, fill_have_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              busrq_n_q, busrq_n_d, bus_en_q, bus_en_d;
  logic [2:0]        stb_q, stb_d;
  logic              byte_done_s, burst_clr_s, hold_en_s;
  logic              burst_limit_s, holdoff_expired_s, skip_rd_s;

  assign burst_clr_s = (state_q == IDLE) || (state_q == HOLD);
  assign hold_en_s   = (state_q == HOLD);
  // Once the fill byte is captured, every later transfer goes straight to WR.
  assign skip_rd_s   = FILL_EN & fill_q & fill_have_q;

  dma_burst_timer #(
    .MAX_BURST(MAX_BURST),
    .HOLDOFF  (HOLDOFF)
  ) u_timer (
    .clk            (clk),
    .reset_n        (reset_n),
    .byte_done      (byte_done_s),
    .burst_clr      (burst_clr_s),
    .hold_en        (hold_en_s),
    .burst_limit    (burst_limit_s),
    .holdoff_expired(holdoff_expired_s)
  );

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    fill_d      = fill_q;
    fill_have_d = fill_have_q;
    dma_do_d    = dma_do_q;
    byte_done_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (len != 16'd0)) begin
          state_d     = REQ;
          src_d       = src;
          dst_d       = dst;
          rem_d       = len;
          fill_d      = fill;
          fill_have_d = 1'b0;
        end else if (start) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (!busak_n) begin
          state_d = skip_rd_s ? WR : RD;
        end else begin
          state_d = REQ;
        end
      end
      RD: begin
        if (busak_n) begin
          state_d = IDLE;
        end else begin
          state_d     = WR;
          dma_do_d    = dma_di;
          fill_have_d = 1'b1;
        end
      end
      WR: begin
        if (busak_n) begin
          state_d = IDLE;
        end else begin
          byte_done_s = 1'b1;
          src_d       = src_q + 16'd1;
          dst_d       = dst_q + 16'd1;
          rem_d       = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = REL_LAST;
          end else if (burst_limit_s) begin
            state_d = REL_BURST;
          end else if (skip_rd_s) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      REL_BURST: begin
        if (busak_n) begin
          state_d = HOLD;
        end else begin
          state_d = REL_BURST;
        end
      end
      REL_LAST: begin
        if (busak_n) begin
          state_d = DONE;
        end else begin
          state_d = REL_LAST;
        end
      end
      HOLD: begin
        if (holdoff_expired_s) begin
          state_d = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d    = !(state_d inside {IDLE, DONE});
    done_d    = (state_d == DONE);
    busrq_n_d = !(state_d inside {REQ, RD, WR});
    bus_en_d  = (state_d inside {RD, WR});
    stb_d     = strobes_for(state_d);
    if (state_d == RD) begin
      dma_a_d = src_d;
    end else if (state_d == WR) begin
      dma_a_d = dst_d;
    end else begin
      dma_a_d = dma_a_q;
    end
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      src_q       <= 16'd0;
      dst_q       <= 16'd0;
      rem_q       <= 16'd0;
      fill_q      <= 1'b0;
      fill_have_q <= 1'b0;
      dma_do_q    <= 8'd0;
      dma_a_q     <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      busrq_n_q   <= 1'b1;
      bus_en_q    <= 1'b0;
      stb_q       <= BUS_IDLE;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      fill_q      <= fill_d;
      fill_have_q <= fill_have_d;
      dma_do_q    <= dma_do_d;
      dma_a_q     <= dma_a_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      busrq_n_q   <= busrq_n_d;
      bus_en_q    <= bus_en_d;
      stb_q       <= stb_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign busrq_n    = busrq_n_q;
  assign dma_bus_en = bus_en_q;
  assign dma_a      = dma_a_q;
  assign dma_do     = dma_do_q;
  assign {dma_mreq_n, dma_rd_n, dma_wr_n} = stb_q;

endmodule

// File: tb/tb_z80_busrq_dma.sv
// Directed bench for z80_busrq_dma: an unlimited-burst and a 2-byte-burst instance share a
// negedge memory model and a CPU stand-in that answers busrq_n one cycle later.
`timescale 1ns/1ps
module tb_z80_busrq_dma;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, fill, sel_b;
  logic [15:0] src, dst, len;
  logic [7:0]  dma_di;
  logic        busak_a, busak_b, start_a, start_b;
  logic        busy_a, done_a, busrq_n_a, bus_en_a, mreq_n_a, rd_n_a, wr_n_a;
  logic        busy_b, done_b, busrq_n_b, bus_en_b, mreq_n_b, rd_n_b, wr_n_b;
  logic [15:0] a_a, a_b;
  logic [7:0]  do_a, do_b;

  assign start_a = start & ~sel_b;
  assign start_b = start & sel_b;

  z80_busrq_dma #(.MAX_BURST(0), .HOLDOFF(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .src(src), .dst(dst), .len(len),
    .fill(fill), .busy(busy_a), .done(done_a), .busrq_n(busrq_n_a), .busak_n(busak_a),
    .dma_bus_en(bus_en_a), .dma_a(a_a), .dma_do(do_a), .dma_di(dma_di),
    .dma_mreq_n(mreq_n_a), .dma_rd_n(rd_n_a), .dma_wr_n(wr_n_a));

  z80_busrq_dma #(.MAX_BURST(2), .HOLDOFF(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .src(src), .dst(dst), .len(len),
    .fill(fill), .busy(busy_b), .done(done_b), .busrq_n(busrq_n_b), .busak_n(busak_b),
    .dma_bus_en(bus_en_b), .dma_a(a_b), .dma_do(do_b), .dma_di(dma_di),
    .dma_mreq_n(mreq_n_b), .dma_rd_n(rd_n_b), .dma_wr_n(wr_n_b));

  logic        m_busy, m_done, m_busrq_n, m_bus_en, m_mreq_n, m_rd_n, m_wr_n;
  logic [15:0] m_a;
  logic [7:0]  m_do;
  assign m_busy    = sel_b ? busy_b    : busy_a;
  assign m_done    = sel_b ? done_b    : done_a;
  assign m_busrq_n = sel_b ? busrq_n_b : busrq_n_a;
  assign m_bus_en  = sel_b ? bus_en_b  : bus_en_a;
  assign m_mreq_n  = sel_b ? mreq_n_b  : mreq_n_a;
  assign m_rd_n    = sel_b ? rd_n_b    : rd_n_a;
  assign m_wr_n    = sel_b ? wr_n_b    : wr_n_a;
  assign m_a       = sel_b ? a_b       : a_a;
  assign m_do      = sel_b ? do_b      : do_a;

  // Memory: acts on negedge, read data registered.
  logic [7:0]  mem [0:65535];
  logic        poke_en;
  logic [15:0] poke_a;
  logic [7:0]  poke_d;
  always @(negedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    else if (!m_mreq_n && !m_wr_n) mem[m_a] <= m_do;
    if (!m_mreq_n && !m_rd_n) dma_di <= mem[m_a];
  end

  // CPU stand-in: grants one cycle after request, runs its loop only while not granted.
  int cpu_steps = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busak_a <= 1'b1;
      busak_b <= 1'b1;
    end else begin
      busak_a <= busrq_n_a;
      busak_b <= busrq_n_b;
    end
  end
  always @(posedge clk) if (busak_a && busak_b) cpu_steps <= cpu_steps + 1;

  // Bus activity monitor.
  int rd_cnt = 0, wr_cnt = 0, data_cyc = 0, done_cnt = 0, tenures = 0, viol = 0;
  int gap = 0, gap_n = 0;
  int gaps [0:15];
  logic prev_busrq = 1'b1;
  logic bad_a, bad_b;
  assign bad_a = ((!mreq_n_a || !rd_n_a || !wr_n_a) && !bus_en_a) || (!rd_n_a && !wr_n_a);
  assign bad_b = ((!mreq_n_b || !rd_n_b || !wr_n_b) && !bus_en_b) || (!rd_n_b && !wr_n_b);
  always @(negedge clk) begin
    prev_busrq <= m_busrq_n;
    if (!m_rd_n) rd_cnt <= rd_cnt + 1;
    if (!m_wr_n) wr_cnt <= wr_cnt + 1;
    if (m_bus_en) data_cyc <= data_cyc + 1;
    if (m_done) done_cnt <= done_cnt + 1;
    if (prev_busrq && !m_busrq_n) tenures <= tenures + 1;
    if (m_busy && m_busrq_n) gap <= gap + 1;
    else begin
      if (!m_busrq_n && gap != 0 && gap_n < 16) begin
        gaps[gap_n] <= gap;
        gap_n <= gap_n + 1;
      end
      gap <= 0;
    end
    viol <= viol + int'(bad_a) + int'(bad_b);
  end

  int total = 0, bad = 0;

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    poke_a = a; poke_d = d; poke_en = 1'b1;
    @(negedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic kick(input logic use_b, input logic [15:0] s, input logic [15:0] d,
                      input logic [15:0] n, input logic f);
    @(negedge clk);
    sel_b = use_b; src = s; dst = d; len = n; fill = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({busy_a, done_a, busrq_n_a, bus_en_a, mreq_n_a, rd_n_a, wr_n_a} !== 7'b0010111) begin
      bad++; $display("FAIL reset_ctl_a got=%b want=0010111",
        {busy_a, done_a, busrq_n_a, bus_en_a, mreq_n_a, rd_n_a, wr_n_a});
    end
    total++;
    if ({a_a, do_a} !== 24'h0) begin
      bad++; $display("FAIL reset_bus_a got=%h want=000000", {a_a, do_a});
    end
    total++;
    if ({busy_b, done_b, busrq_n_b, bus_en_b, mreq_n_b, rd_n_b, wr_n_b} !== 7'b0010111) begin
      bad++; $display("FAIL reset_ctl_b got=%b want=0010111",
        {busy_b, done_b, busrq_n_b, bus_en_b, mreq_n_b, rd_n_b, wr_n_b});
    end
  endtask

  task automatic test_copy();
    logic [7:0] exp_v [0:3];
    logic ok;
    int ten0, dc0, dn0, s0;
    exp_v[0] = 8'h11; exp_v[1] = 8'h22; exp_v[2] = 8'h33; exp_v[3] = 8'h44;
    for (int i = 0; i < 4; i++) poke(16'(32'h0100 + i), exp_v[i]);
    ten0 = tenures; dc0 = data_cyc; dn0 = done_cnt;
    kick(1'b0, 16'h0100, 16'h0200, 16'd4, 1'b0);
    wait_done(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL copy_timeout got=no_done want=done"); end
    repeat (4) @(negedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[16'(32'h0200 + i)] !== exp_v[i]) begin
        bad++; $display("FAIL copy_byte%0d got=%h want=%h", i, mem[16'(32'h0200 + i)], exp_v[i]);
      end
    end
    total++;
    if (tenures - ten0 != 1) begin bad++; $display("FAIL copy_tenures got=%0d want=1", tenures - ten0); end
    total++;
    if (data_cyc - dc0 != 8) begin bad++; $display("FAIL copy_data_cycles got=%0d want=8", data_cyc - dc0); end
    total++;
    if (done_cnt - dn0 != 1) begin bad++; $display("FAIL copy_done_pulses got=%0d want=1", done_cnt - dn0); end
    s0 = cpu_steps;
    repeat (5) @(negedge clk); #1;
    total++;
    if (cpu_steps - s0 != 5) begin bad++; $display("FAIL copy_cpu_resume got=%0d want=5", cpu_steps - s0); end
  endtask

  task automatic test_zero_len();
    int ten0;
    ten0 = tenures;
    kick(1'b0, 16'h1234, 16'h5678, 16'd0, 1'b0);
    total++;
    if ({m_done, m_busy, m_busrq_n} !== 3'b101) begin
      bad++; $display("FAIL zero_done got=%b want=101", {m_done, m_busy, m_busrq_n});
    end
    @(negedge clk);
    total++;
    if ({m_done, m_busy, m_busrq_n} !== 3'b001) begin
      bad++; $display("FAIL zero_after got=%b want=001", {m_done, m_busy, m_busrq_n});
    end
    repeat (3) @(negedge clk); #1;
    total++;
    if (tenures != ten0) begin bad++; $display("FAIL zero_busrq got=%0d want=0", tenures - ten0); end
  endtask

  task automatic test_burst_split();
    logic ok;
    int ten0, g0, dc0;
    for (int i = 0; i < 5; i++) poke(16'(32'h0500 + i), 8'(8'h9A + i));
    ten0 = tenures; g0 = gap_n; dc0 = data_cyc;
    kick(1'b1, 16'h0500, 16'h0600, 16'd5, 1'b0);
    wait_done(300, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL burst_timeout got=no_done want=done"); end
    repeat (4) @(negedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (mem[16'(32'h0600 + i)] !== 8'(8'h9A + i)) begin
        bad++; $display("FAIL burst_byte%0d got=%h want=%h", i, mem[16'(32'h0600 + i)], 8'(8'h9A + i));
      end
    end
    total++;
    if (tenures - ten0 != 3) begin bad++; $display("FAIL burst_tenures got=%0d want=3", tenures - ten0); end
    total++;
    if (data_cyc - dc0 != 10) begin bad++; $display("FAIL burst_data_cycles got=%0d want=10", data_cyc - dc0); end
    total++;
    if (gap_n - g0 != 2) begin
      bad++; $display("FAIL burst_gap_count got=%0d want=2", gap_n - g0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (gaps[g0 + i] < 8) begin bad++; $display("FAIL burst_gap%0d got=%0d want>=8", i, gaps[g0 + i]); end
      end
    end
    sel_b = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_v [0:3];
    logic ok;
    exp_v[0] = 8'hA1; exp_v[1] = 8'hA2; exp_v[2] = 8'hA3; exp_v[3] = 8'hA4;
    poke(16'hFFFE, exp_v[0]); poke(16'hFFFF, exp_v[1]);
    poke(16'h0000, exp_v[2]); poke(16'h0001, exp_v[3]);
    kick(1'b0, 16'hFFFE, 16'h0010, 16'd4, 1'b0);
    wait_done(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_timeout got=no_done want=done"); end
    repeat (2) @(negedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[16'(32'h0010 + i)] !== exp_v[i]) begin
        bad++; $display("FAIL wrap_byte%0d got=%h want=%h", i, mem[16'(32'h0010 + i)], exp_v[i]);
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp_v [0:5];
    logic ok;
    int rd0, exp_rd;
    poke(16'h0300, 8'h5A);
    for (int i = 1; i < 6; i++) poke(16'(32'h0300 + i), 8'(8'h60 + i));
`ifdef DMA_FILL_EN
    for (int i = 0; i < 6; i++) exp_v[i] = 8'h5A;
    exp_rd = 1;
`else
    exp_v[0] = 8'h5A;
    for (int i = 1; i < 6; i++) exp_v[i] = 8'(8'h60 + i);
    exp_rd = 6;
`endif
    rd0 = rd_cnt;
    kick(1'b0, 16'h0300, 16'h0400, 16'd6, 1'b1);
    wait_done(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL fill_timeout got=no_done want=done"); end
    repeat (2) @(negedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (mem[16'(32'h0400 + i)] !== exp_v[i]) begin
        bad++; $display("FAIL fill_byte%0d got=%h want=%h", i, mem[16'(32'h0400 + i)], exp_v[i]);
      end
    end
    total++;
    if (rd_cnt - rd0 != exp_rd) begin bad++; $display("FAIL fill_rd_count got=%0d want=%0d", rd_cnt - rd0, exp_rd); end
  endtask

  task automatic test_reset_midop();
    int k, dn0, s0;
    for (int i = 0; i < 8; i++) poke(16'(32'h0700 + i), 8'(8'h71 + i));
    for (int i = 0; i < 8; i++) poke(16'(32'h0800 + i), 8'hEE);
    dn0 = done_cnt;
    kick(1'b0, 16'h0700, 16'h0800, 16'd8, 1'b0);
    k = 0;
    for (int i = 0; i < 100 && k < 2; i++) begin
      @(negedge clk);
      if (!m_wr_n) k++;
    end
    total++;
    if (k != 2) begin bad++; $display("FAIL midop_wr_seen got=%0d want=2", k); end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    total++;
    if ({busrq_n_a, bus_en_a, busy_a, mreq_n_a} !== 4'b1001) begin
      bad++; $display("FAIL midop_async got=%b want=1001", {busrq_n_a, bus_en_a, busy_a, mreq_n_a});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk); #1;
    total++;
    if ({mem[16'h0800], mem[16'h0801], mem[16'h0802]} !== 24'h7172EE) begin
      bad++; $display("FAIL midop_mem got=%h want=7172ee", {mem[16'h0800], mem[16'h0801], mem[16'h0802]});
    end
    total++;
    if (done_cnt != dn0) begin bad++; $display("FAIL midop_done got=%0d want=0", done_cnt - dn0); end
    s0 = cpu_steps;
    repeat (5) @(negedge clk); #1;
    total++;
    if (cpu_steps - s0 != 5) begin bad++; $display("FAIL midop_cpu_resume got=%0d want=5", cpu_steps - s0); end
  endtask

  task automatic test_invariants();
    total++;
    if (viol != 0) begin bad++; $display("FAIL strobe_rules got=%0d want=0", viol); end
  endtask

  initial begin
    start = 1'b0; fill = 1'b0; sel_b = 1'b0;
    src = 16'd0; dst = 16'd0; len = 16'd0;
    poke_en = 1'b0; poke_a = 16'd0; poke_d = 8'd0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    test_copy();
    test_zero_len();
    test_burst_split();
    test_wrap();
    test_fill();
    test_reset_midop();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
